// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART TX and RX paths: the transmitter state
//   encoding, the frame data width and the baud-divider helper. The RX side
//   uses the same helper so both directions derive an identical bit period
//   from the same CLK_FREQ/BAUD pair.
// ---------------------------------------------------------------------------
package uart_pkg;

    // Transmitter FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Payload bits per frame (8N1).
    localparam int DATA_BITS = 8;

    // System clocks per serial bit. Integer division truncates: the bit period
    // is slightly short when CLK_FREQ is not an exact multiple of BAUD.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage : uart_pkg

// File: rtl/uart_tx_if.sv
// ---------------------------------------------------------------------------
// uart_tx_if
//   Send-side handshake and serial line of the UART transmitter.
//   Signals:
//     tx_data  byte to send, sampled only when a request is accepted
//     tx_send  send request, accepted when tx_send && !tx_busy at a clock edge
//     tx_busy  high while a frame is in flight; requests are ignored then
//     tx_done  one-cycle pulse on the cycle after the stop bit completes
//     tx       serial line, idle high
//   Modports:
//     master   the client that requests bytes (drives tx_data/tx_send)
//     slave    the transmitter (drives tx_busy/tx_done/tx)
// ---------------------------------------------------------------------------
interface uart_tx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_send;
    logic                 tx_busy;
    logic                 tx_done;
    logic                 tx;

    modport master (
        output tx_data,
        output tx_send,
        input  tx_busy,
        input  tx_done,
        input  tx
    );

    modport slave (
        input  tx_data,
        input  tx_send,
        output tx_busy,
        output tx_done,
        output tx
    );

endinterface : uart_tx_if

// File: rtl/uart_tx_datapath.sv
// ---------------------------------------------------------------------------
// uart_tx_datapath
//   Datapath of the UART transmitter: an 8-bit parallel-in/serial-out shift
//   register, the baud counter that times each bit period, and the counter of
//   data bits already sent. All sequencing decisions live in the FSM in
//   uart_tx; this block only obeys its strobes.
//   Ports:
//     clock, reset  system clock (rising edge), asynchronous active-high reset
//     load          copy load_data into the shift register
//     load_data     byte to serialise
//     shift         shift the register right by one bit
//     bit_inc       advance the data-bit counter (saturates at the last bit)
//     count_clr     clear baud and bit counters (frame start)
//     count_en      let the baud counter run (a frame is in flight)
//     bit_end       the current cycle is the last one of a bit period
//     last_bit      the data-bit counter is on the final data bit
//     serial_bit    bit at the head of the shift register (LSB first)
// ---------------------------------------------------------------------------
module uart_tx_datapath
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] load_data,
    input  logic                 shift,
    input  logic                 bit_inc,
    input  logic                 count_clr,
    input  logic                 count_en,
    output logic                 bit_end,
    output logic                 last_bit,
    output logic                 serial_bit
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_BITS - 1);

    logic [DATA_BITS-1:0] shreg_q,    shreg_d;
    logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q,  bit_cnt_d;

    assign bit_end    = (baud_cnt_q == CNT_MAX);
    assign last_bit   = (bit_cnt_q == BIT_MAX);
    assign serial_bit = shreg_q[0];

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the block leaves it unassigned and no latch is inferred.
        shreg_d    = shreg_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;

        if (load) begin
            shreg_d = load_data;
        end else if (shift) begin
            shreg_d = {1'b0, shreg_q[DATA_BITS-1:1]};
        end

        // Clearing on acceptance makes the start bit a full bit period no
        // matter where the counter sat while idle.
        if (count_clr) begin
            baud_cnt_d = '0;
        end else if (count_en) begin
            baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;
        end

        // Saturate rather than wrap: the FSM leaves DATA on the bit end seen
        // with last_bit high, so the counter never needs to pass 7.
        if (count_clr) begin
            bit_cnt_d = '0;
        end else if (bit_inc && !last_bit) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state is updated only with non-blocking assignments
        // so every flop samples its pre-edge inputs regardless of block order.
        if (reset) begin
            shreg_q    <= '0;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            shreg_q    <= shreg_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

endmodule : uart_tx_datapath

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
//   UART transmitter, 8N1, LSB first. One byte is accepted per tx_send
//   handshake and serialised onto tx at BAUD, timed from the system clock.
//   The FSM and all output registers live here; shifting and bit timing are
//   delegated to uart_tx_datapath.
//   Parameters:
//     CLK_FREQ  system clock frequency in Hz
//     BAUD      line rate in bits/s (CLK_FREQ/BAUD must be at least 2)
//   Ports:
//     clock     system clock, rising edge
//     reset     asynchronous active-high reset; aborts any frame in flight
//     bus       uart_tx_if slave: tx_data/tx_send in, tx_busy/tx_done/tx out
//   Timing:
//     The edge that accepts tx_send drives tx low and tx_busy high from the
//     next cycle. tx_busy stays high for exactly 10*CLKS_PER_BIT cycles; the
//     edge ending the stop bit drops tx_busy and pulses tx_done for one cycle.
//     A request accepted during that tx_done cycle starts the next frame with
//     no extra idle time on the line.
// ---------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
) (
    input  logic     clock,
    input  logic     reset,
    uart_tx_if.slave bus
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_tx: CLK_FREQ/BAUD = %0d, must be at least 2", CLKS_PER_BIT);
        end
    endgenerate

    tx_state_t state_q, state_d;
    logic      tx_q,    tx_d;
    logic      busy_q,  busy_d;
    logic      done_q,  done_d;

    // Datapath strobes and status.
    logic load;
    logic shift;
    logic bit_inc;
    logic count_clr;
    logic bit_end;
    logic last_bit;
    logic serial_bit;

    uart_tx_datapath #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_datapath (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .load_data  (bus.tx_data),
        .shift      (shift),
        .bit_inc    (bit_inc),
        .count_clr  (count_clr),
        .count_en   (busy_q),
        .bit_end    (bit_end),
        .last_bit   (last_bit),
        .serial_bit (serial_bit)
    );

    // Next-state and next-output logic. tx is a register whose next value is
    // chosen one edge ahead: the bit about to go on the line is read from the
    // head of the shift register at the end of the previous bit period, and
    // the register is shifted on that same edge.
    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        bit_inc   = 1'b0;
        count_clr = 1'b0;

        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (bus.tx_send && !busy_q) begin
                    state_d   = START;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                    load      = 1'b1;
                    count_clr = 1'b1;
                end
            end

            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = serial_bit;
                    shift   = 1'b1;
                end
            end

            DATA: begin
                if (bit_end) begin
                    if (last_bit) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d    = serial_bit;
                        shift   = 1'b1;
                        bit_inc = 1'b1;
                    end
                end
            end

            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Reset forces the line high immediately, abandoning any frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.tx      = tx_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
//   Self-checking bench for uart_tx at CLK_FREQ=1 MHz, BAUD=100 kHz
//   (10 clocks per bit). Inputs are driven and outputs sampled on the falling
//   clock edge. A mid-bit sampler decodes every frame on tx and compares it
//   against a queue of bytes pushed when each send is driven.
// ---------------------------------------------------------------------------
module tb_uart_tx;

    localparam int CPB       = 10;
    localparam int FRAME_CYC = 10 * CPB;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // line level per bit period: [0]=start .. [9]=stop
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;

    uart_tx_if u_if ();

    uart_tx #(
        .CLK_FREQ (1_000_000),
        .BAUD     (100_000)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (u_if.slave)
    );

    always #5 clock = ~clock;

    int         n_checks = 0;
    int         n_err    = 0;
    logic [7:0] sb[$];
    logic       mon_en   = 1'b0;
    int         rx_cnt   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one request on a falling edge; returns on the next falling edge,
    // which is cycle 0 of the frame when the request is accepted.
    task automatic send(input logic [7:0] d, input logic push);
        u_if.tx_data = d;
        u_if.tx_send = 1'b1;
        if (push) sb.push_back(d);
        @(negedge clock);
        u_if.tx_send = 1'b0;
    endtask

    // Watch one frame cycle by cycle from cycle 0; returns at the done cycle.
    // Optionally holds tx_send high with spam_data over cycles spam_lo..spam_hi.
    task automatic watch_frame(input logic [9:0] lvl, input int spam_lo, input int spam_hi,
                               input logic [7:0] spam_data,
                               output int tx_err, output int busy_cnt, output int done_cnt);
        tx_err   = 0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < FRAME_CYC; c++) begin
            if (c >= spam_lo && c <= spam_hi) begin
                u_if.tx_send = 1'b1;
                u_if.tx_data = spam_data;
            end else begin
                u_if.tx_send = 1'b0;
            end
            if (u_if.tx !== lvl[c / CPB]) tx_err++;
            if (u_if.tx_busy === 1'b1) busy_cnt++;
            if (u_if.tx_done !== 1'b0) done_cnt++;
            @(negedge clock);
        end
        u_if.tx_send = 1'b0;
    endtask

    task automatic check_done_cycle(input string tag);
        check({tag, "_done_pulse"}, u_if.tx_done, 1);
        check({tag, "_busy_clear"}, u_if.tx_busy, 0);
        check({tag, "_line_high"},  u_if.tx,      1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int te, bc, dc;
        check({tag, "_idle_before"}, u_if.tx_busy, 0);
        send(v.data, 1'b1);
        watch_frame(v.frame, -1, -1, 8'h00, te, bc, dc);
        check({tag, "_tx_level_errs"}, te, 0);
        check({tag, "_busy_cycles"},   bc, FRAME_CYC);
        check({tag, "_early_done"},    dc, 0);
        check_done_cycle(tag);
        @(negedge clock);
        check({tag, "_done_one_cycle"}, u_if.tx_done, 0);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (u_if.tx_done !== 1'b1 && n < FRAME_CYC + 2 * CPB) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_done_seen"}, u_if.tx_done, 1);
    endtask

    // Mid-bit 8N1 sampler. The first low sample seen while idle is cycle 0 of
    // the start bit; mid-bit points are then CPB/2 + k*CPB cycles later.
    initial begin : sampler
        logic [7:0] b;
        logic [7:0] exp_b;
        b = '0;
        forever begin
            @(negedge clock);
            if (mon_en && !reset && u_if.tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clock);
                check("rx_start_mid", u_if.tx, 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clock);
                    b[i] = u_if.tx;
                end
                repeat (CPB) @(negedge clock);
                check("rx_stop_mid", u_if.tx, 1);
                check("rx_expected_frame", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    exp_b = sb.pop_front();
                    check("rx_byte", b, exp_b);
                end
                rx_cnt++;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t vecs[6];
        int   te, bc, dc, bc2;
        int   bad_tx, bad_busy, bad_done, rx_base;
        logic [7:0] rnd;

        vecs[0] = '{data: 8'hA5, frame: 10'b1101001010};
        vecs[1] = '{data: 8'h00, frame: 10'b1000000000};
        vecs[2] = '{data: 8'hFF, frame: 10'b1111111110};
        vecs[3] = '{data: 8'h3C, frame: 10'b1001111000};
        vecs[4] = '{data: 8'h81, frame: 10'b1100000010};
        vecs[5] = '{data: 8'h55, frame: 10'b1010101010};

        u_if.tx_data = 8'h00;
        u_if.tx_send = 1'b0;

        // Asynchronous reset takes effect before any clock edge.
        #2 reset = 1'b1;
        #1;
        check("reset_tx",   u_if.tx,      1);
        check("reset_busy", u_if.tx_busy, 0);
        check("reset_done", u_if.tx_done, 0);
        repeat (3) @(negedge clock);
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clock);

        // Single frames from the vector table (0xA5 first).
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            repeat (3) @(negedge clock);
        end

        // Back-to-back: 0x00 then 0xFF requested in the tx_done cycle.
        send(8'h00, 1'b1);
        watch_frame(vecs[1].frame, -1, -1, 8'h00, te, bc, dc);
        check("b2b_f1_tx_level_errs", te, 0);
        check_done_cycle("b2b_f1");
        send(8'hFF, 1'b1);
        check("b2b_f2_start_immediate", u_if.tx, 0);
        watch_frame(vecs[2].frame, -1, -1, 8'h00, te, bc2, dc);
        check("b2b_f2_tx_level_errs", te, 0);
        check("b2b_total_busy", bc + bc2, 2 * FRAME_CYC);
        check("b2b_early_done", dc, 0);
        check_done_cycle("b2b_f2");
        repeat (3) @(negedge clock);

        // Requests with 0x3C during cycles 5..50 of a 0x81 frame are dropped.
        send(8'h81, 1'b1);
        watch_frame(vecs[4].frame, 5, 50, 8'h3C, te, bc, dc);
        check("drop_tx_level_errs", te, 0);
        check("drop_busy_cycles",   bc, FRAME_CYC);
        check_done_cycle("drop");
        bad_busy = 0;
        bad_tx   = 0;
        for (int c = 0; c < 3 * CPB; c++) begin
            @(negedge clock);
            if (u_if.tx_busy !== 1'b0) bad_busy++;
            if (u_if.tx !== 1'b1) bad_tx++;
        end
        check("drop_no_second_busy", bad_busy, 0);
        check("drop_no_second_tx",   bad_tx,   0);

        // Reset mid-frame during data bit 4 of 0x55.
        mon_en = 1'b0;
        send(8'h55, 1'b0);
        repeat (CPB + 4 * CPB + 3) @(negedge clock);
        check("abort_busy_before", u_if.tx_busy, 1);
        #2 reset = 1'b1;
        #1;
        check("abort_tx_high",  u_if.tx,      1);
        check("abort_busy_low", u_if.tx_busy, 0);
        check("abort_no_done",  u_if.tx_done, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        bad_done = 0;
        bad_tx   = 0;
        bad_busy = 0;
        for (int c = 0; c < 2 * CPB; c++) begin
            @(negedge clock);
            if (u_if.tx_done !== 1'b0) bad_done++;
            if (u_if.tx !== 1'b1) bad_tx++;
            if (u_if.tx_busy !== 1'b0) bad_busy++;
        end
        check("abort_after_done", bad_done, 0);
        check("abort_after_tx",   bad_tx,   0);
        check("abort_after_busy", bad_busy, 0);
        mon_en = 1'b1;
        run_vec(vecs[5], "abort_resend");

        // Long idle.
        bad_done = 0;
        bad_tx   = 0;
        bad_busy = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clock);
            if (u_if.tx_done !== 1'b0) bad_done++;
            if (u_if.tx !== 1'b1) bad_tx++;
            if (u_if.tx_busy !== 1'b0) bad_busy++;
        end
        check("idle_tx",   bad_tx,   0);
        check("idle_busy", bad_busy, 0);
        check("idle_done", bad_done, 0);

        // 256 random bytes back to back, checked by the sampler.
        rx_base = rx_cnt;
        rnd = 8'($urandom_range(0, 255));
        send(rnd, 1'b1);
        for (int i = 1; i < 256; i++) begin
            wait_done("rand");
            rnd = 8'($urandom_range(0, 255));
            send(rnd, 1'b1);
        end
        wait_done("rand");
        repeat (2 * CPB) @(negedge clock);
        check("rand_frames_rx", rx_cnt - rx_base, 256);
        check("sb_empty",       sb.size(),        0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_uart_tx
